// File: rtl/rr_arb_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arb_8_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dec_3_8.sv
// 3-to-8 one-hot decoder.
module dec_3_8 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);

  assign dec = 8'd1 << sel;

endmodule

// File: rtl/rr_pick.sv
// Circular priority finder: first set req bit at or after ptr, wrapping 7->0.
module rr_pick
  import rr_arb_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] j;

  // Scan from the far end so the closest hit to ptr wins last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = ptr + IDX_W'(k);
      if (req[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_8.sv
// 8-way round-robin arbiter with done/req-drop release and one idle bubble.
// Define RR_ARB_TIMEOUT_EN to add the MAX_HOLD forced-release counter.
module rr_arb_8
  import rr_arb_8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arb_8: MAX_HOLD must be in 2..255");
  end

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             rel;
  logic             hold_exp;
  logic [N_REQ-1:0] dec;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  dec_3_8 u_dec (
    .sel(gnt_idx),
    .dec(dec)
  );

  assign rel = done | ~req[gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold;

  assign hold_exp = (state == GRANT) && (hold == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      hold    <= (state == GRANT) ? hold + 8'd1 : '0;
      timeout <= (state == GRANT) && hold_exp && !rel;
    end
  end
`else
  assign hold_exp = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = GRANT;
          idx_n   = pick_idx;
        end
      end
      GRANT: begin
        if (rel || hold_exp) begin
          state_n = IDLE;
          ptr_n   = gnt_idx + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_idx <= idx_n;
    end
  end

  assign busy = (state == GRANT);
  assign gnt  = dec & {N_REQ{busy}};

endmodule

// File: tb/tb_rr_arb_8.sv
// Randomized + directed bench for rr_arb_8 against a behavioural model.
module tb_rr_arb_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arb_8 #(.MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .busy   (busy),
    .timeout(timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_cnt;
  bit m_to;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_idx  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_to   = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    bit found;
    bit to_n;
    found = 0;
    to_n  = 0;
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (m_ptr + k) % 8;
        if (!found && r[j]) begin
          found  = 1;
          m_idx  = j;
          m_busy = 1;
          m_cnt  = 0;
        end
      end
    end else if (d || !r[m_idx]) begin
      m_busy = 0;
      m_ptr  = (m_idx + 1) % 8;
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      if (m_cnt == MH - 1) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
        to_n   = 1;
      end else begin
        m_cnt++;
      end
`endif
    end
    m_to = to_n;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"}, int'(gnt), m_busy ? (1 << m_idx) : 0);
    chk({tag, ".idx"}, int'(gnt_idx), m_idx);
    chk({tag, ".busy"}, int'(busy), int'(m_busy));
    chk({tag, ".to"}, int'(timeout), int'(m_to));
    chk({tag, ".oh"}, int'($onehot0(gnt)), 1);
  endtask

  task automatic step(input logic [7:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst");
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] r;
    req  = '0;
    done = 1'b0;
    rst  = 1'b0;
    model_reset();

    do_reset();

    step(8'h01, 1'b0, "basic_gnt");
    chk("basic_gnt0", int'(gnt), 8'h01);
    step(8'h01, 1'b1, "basic_rel");
    chk("basic_rel0", int'(gnt), 0);
    step(8'h03, 1'b0, "basic_ptr1");
    chk("basic_ptr1_idx", int'(gnt_idx), 1);

    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, "ord_g");
      chk("ord_idx", int'(gnt_idx), k % 8);
      step(8'hFF, 1'b1, "ord_r");
      chk("ord_bubble", int'(busy), 0);
    end

    do_reset();
    step(8'h10, 1'b0, "wrap_a");
    step(8'h10, 1'b1, "wrap_b");
    step(8'h11, 1'b0, "wrap_c");
    chk("wrap_idx0", int'(gnt_idx), 0);
    step(8'h11, 1'b1, "wrap_d");
    step(8'h11, 1'b0, "wrap_e");
    chk("wrap_idx4", int'(gnt_idx), 4);

    do_reset();
    step(8'h04, 1'b0, "hold_g");
`ifdef RR_ARB_TIMEOUT_EN
    repeat (MH - 1) step(8'h04, 1'b0, "hold_h");
    chk("hold_busy4", int'(busy), 1);
    step(8'h04, 1'b0, "hold_rel");
    chk("to_pulse", int'(timeout), 1);
    chk("to_gnt0", int'(gnt), 0);
    step(8'h04, 1'b0, "hold_regnt");
    chk("to_clear", int'(timeout), 0);
    repeat (MH - 1) step(8'h04, 1'b0, "co_h");
    step(8'h04, 1'b1, "co_rel");
    chk("co_noto", int'(timeout), 0);
`else
    repeat (100) step(8'h04, 1'b0, "persist");
    chk("persist_gnt", int'(gnt), 8'h04);
`endif

    do_reset();
    step(8'h40, 1'b0, "mid_g");
    chk("mid_idx6", int'(gnt_idx), 6);
    rst = 1'b1;
    #1;
    chk("mid_async", int'(gnt), 0);
    #1;
    model_reset();
    rst = 1'b0;
    #1;
    step(8'h41, 1'b0, "mid_after");
    chk("mid_idx0", int'(gnt_idx), 0);

    do_reset();
    r = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      if ($urandom_range(0, 15) == 0) r = '0;
      step(r, ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
